// File: rtl/keccak_padder_p.sv
// Keccak/SHA-3 input padder: packs message words into one RATE-bit block,
// applies pad10*1 with a configurable domain-separation suffix on the final
// word, and hands complete blocks to the permutation via buffer_full/f_ack.
module keccak_padder_p #(
  parameter int unsigned IN_W   = 32,
  parameter int unsigned RATE   = 1088,
  parameter logic [7:0]  SUFFIX = 8'h06,
  localparam int unsigned BN_W  = $clog2(IN_W / 8)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IN_W-1:0]   in,
  input  logic              in_ready,
  input  logic              is_last,
  input  logic [BN_W-1:0]   byte_num,
  input  logic              f_ack,
  output logic              buffer_full,
  output logic [RATE-1:0]   out,
  output logic              out_ready
);

  localparam int unsigned W     = RATE / IN_W;
  localparam int unsigned CNT_W = $clog2(W + 1);
  localparam int unsigned NB    = IN_W / 8;

  typedef enum logic [1:0] {
    S_ACCEPT = 2'd0,
    S_FULL   = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             full_q, full_d;
  logic [RATE-1:0]  out_q, out_d;

  logic             accept_c;
  logic [IN_W-1:0]  word_c;

  // A word is taken only while collecting and the block is not yet full.
  assign accept_c = (state_q == S_ACCEPT) && in_ready && !full_q;

  // Final word: keep byte_num leading bytes, then the suffix, then zeros.
  always_comb begin
    word_c = in;
    if (is_last) begin
      for (int j = 0; j < int'(NB); j++) begin
        if (BN_W'(j) == byte_num) begin
          word_c[IN_W-1-8*j -: 8] = SUFFIX;
        end else if (BN_W'(j) > byte_num) begin
          word_c[IN_W-1-8*j -: 8] = 8'h00;
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_ACCEPT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ACCEPT: begin
        if (accept_c && (is_last || cnt_q == CNT_W'(W - 1))) begin
          state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (f_ack) begin
          state_d = last_q ? S_DONE : S_ACCEPT;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_ACCEPT;
    endcase
  end

  // Datapath and flag next values.
  always_comb begin
    out_d  = out_q;
    cnt_d  = cnt_q;
    last_d = last_q;
    full_d = (state_d == S_FULL);
    case (state_q)
      S_ACCEPT: begin
        if (accept_c) begin
          for (int k = 0; k < int'(W); k++) begin
            if (CNT_W'(k) == cnt_q) begin
              out_d[RATE-1-k*IN_W -: IN_W] = word_c;
            end else if (is_last && (CNT_W'(k) > cnt_q)) begin
              out_d[RATE-1-k*IN_W -: IN_W] = '0;
            end
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (is_last) begin
            last_d     = 1'b1;
            out_d[7:0] = out_d[7:0] | 8'h80;
          end
        end
      end
      S_FULL: begin
        if (f_ack) begin
          out_d = '0;
          cnt_d = '0;
        end
      end
      S_DONE: begin
        out_d = '0;
      end
      default: begin
        out_d = '0;
        cnt_d = '0;
      end
    endcase
  end

  // Datapath and flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q  <= '0;
      cnt_q  <= '0;
      last_q <= 1'b0;
      full_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
      full_q <= full_d;
    end
  end

  assign out         = out_q;
  assign buffer_full = full_q;
  assign out_ready   = full_q;

endmodule

// File: doc/keccak_padder_p.md
KECCAK_PADDER_P -- requirements
Module: keccak_padder_p

Interface
REQ-001 SHALL have parameter IN_W, default 32: input word width in bits; legal values 32 or 64.
REQ-002 SHALL have parameter RATE, default 1088: block width in bits; SHALL be a multiple of IN_W; W = RATE/IN_W words per block.
REQ-003 SHALL have parameter SUFFIX, default 8'h06: domain-separation byte (8'h01 Keccak, 8'h06 SHA3, 8'h1F SHAKE).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in  input  IN_W  message word; first byte in bits [IN_W-1:IN_W-8].
REQ-007 in_ready  input  1  in is valid this cycle.
REQ-008 is_last  input  1  current word is the final message word.
REQ-009 byte_num  input  clog2(IN_W/8)  number of valid bytes in the final word (0..IN_W/8-1), MSB-aligned; ignored unless is_last.
REQ-010 f_ack  input  1  consumer has taken the current block.
REQ-011 buffer_full  output  1  block complete; no input accepted.
REQ-012 out  output  RATE  assembled block; word k in out[RATE-1-k*IN_W -: IN_W].
REQ-013 out_ready  output  1  equals buffer_full.

Function
REQ-014 SHALL implement states ACCEPT, FULL, DONE plus a word counter cnt (0..W).
REQ-015 In ACCEPT, a word SHALL be accepted when in_ready=1 and buffer_full=0; it is written into slot cnt at that edge and cnt increments; out reflects it the next cycle.
REQ-016 Non-last accept making cnt=W SHALL move to FULL; buffer_full=1 from the next cycle.
REQ-017 Accept with is_last=1 SHALL, in that same edge: keep byte_num MSB bytes of in, place SUFFIX in the next byte, zero the rest of the word and every remaining slot, OR 8'h80 into out[7:0], set a last flag, go to FULL.
REQ-018 If SUFFIX lands in out[7:0] (last slot, byte_num=IN_W/8-1), that byte SHALL equal SUFFIX|8'h80.
REQ-019 is_last with in_ready=1 while buffer_full=1 SHALL NOT be accepted; upstream holds it.
REQ-020 In FULL, f_ack=1 SHALL clear out to zero and cnt to 0 next edge; go to ACCEPT if the last flag is clear, else to DONE.
REQ-021 f_ack in ACCEPT or DONE SHALL be ignored.
REQ-022 f_ack and in_ready in the same FULL cycle: f_ack acts; in not accepted that cycle.
REQ-023 In DONE, buffer_full=0, out=0, all inputs ignored until reset.
REQ-024 in_ready=0 SHALL hold all state.
REQ-025 Multi-block messages SHALL apply padding only in the block containing the is_last word.

Reset
REQ-026 reset=0 SHALL asynchronously set state ACCEPT, cnt=0, last flag=0, out=0, buffer_full=0, out_ready=0.
REQ-027 Reset mid-block or in FULL/DONE SHALL discard all content; first accept after release goes to slot 0.

Verification
REQ-028 Defaults; in=0x61626300 ("abc"), byte_num=3, is_last=1 -> next cycle out[1087:1056]=0x61626306, out[7:0]=0x80, all else 0, buffer_full=1.
REQ-029 Defaults; first word is_last=1, byte_num=0 -> out[1087:1056]=0x06000000, out[7:0]=0x80; f_ack -> DONE, buffer_full=0, further words ignored.
REQ-030 Defaults; 34 words 0x01..0x22 no is_last -> buffer_full after 34th accept, word 35 ignored while full; f_ack -> buffer_full=0, out=0; then is_last byte_num=0 -> second block 0x06000000...0x80.
REQ-031 Defaults; 33 words then in=0xAABBCC00, byte_num=3, is_last=1 -> out[31:0]=0xAABBCC86.
REQ-032 IN_W=64, RATE=576, SUFFIX=8'h1F; in=0x4142000000000000, byte_num=2, is_last=1 -> out[575:512]=0x41421F0000000000, out[7:0]=0x80.
REQ-033 Assert reset=0 after 5 accepted words, asynchronous to clk -> buffer_full=0, out=0 immediately; next word lands in out[RATE-1 -: IN_W].
